// File: rtl/map_table_pkg.sv
// Shared constants and types for the rename map table: physical-register tag
// width, rename slots per cycle, the CDB completion packet, and a tag-match
// helper used by both the table update and the lookup bypass.
package map_table_pkg;

    localparam int PR    = 6;
    localparam int N_WAY = 3;

    // Three completing tags per cycle; a tag of 0 means no broadcast.
    typedef struct packed {
        logic [PR-1:0] t0;
        logic [PR-1:0] t1;
        logic [PR-1:0] t2;
    } cdb_t_packet_t;

    // True when tag matches any live (nonzero) CDB broadcast.
    function automatic logic cdb_hit(input logic [PR-1:0] tag, input cdb_t_packet_t cdb);
        cdb_hit = ((cdb.t0 != '0) && (cdb.t0 == tag)) ||
                  ((cdb.t1 != '0) && (cdb.t1 == tag)) ||
                  ((cdb.t2 != '0) && (cdb.t2 == tag));
    endfunction

endpackage

// File: rtl/map_table_fwd.sv
// Per-slot lookup of one architectural register: starts from the registered
// table entry, overrides it with the latest same-cycle rename from an older
// slot (higher index), and bypasses CDB completions into the ready flag when
// the tag was not forwarded.
module map_table_fwd
    import map_table_pkg::*;
#(
    parameter int SLOT = 0
) (
    input  logic [4:0]                 lookup_ar,
    input  logic [PR-1:0]              entry_tag,
    input  logic                       entry_ready,
    input  logic [N_WAY-1:0][4:0]      new_ar,
    input  logic [N_WAY-1:0][PR-1:0]   new_pr,
    input  cdb_t_packet_t              cdb_t_in,
    output logic [PR-1:0]              tag,
    output logic                       ready
);

    logic fwd;

    // Walk older slots from oldest to youngest so the latest older rename wins.
    always_comb begin
        tag = entry_tag;
        fwd = 1'b0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if ((i > SLOT) && (new_ar[i] != 5'd0) && (new_ar[i] == lookup_ar)) begin
                tag = new_pr[i];
                fwd = 1'b1;
            end
        end
        ready = fwd ? 1'b0 : (entry_ready || cdb_hit(entry_tag, cdb_t_in));
    end

endmodule

// File: rtl/map_table.sv
// Register rename map table: 32 architectural entries of {PR tag, ready},
// N_WAY renames per cycle with intra-group forwarding, CDB ready update,
// and single-cycle branch-mispredict recovery from the committed map.
// Optional display ports are enabled by defining MAP_TABLE_DISP_EN.
module map_table
    import map_table_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0][PR-1:0]        archi_maptable,
    input  logic                       BPRecoverEN,
    input  cdb_t_packet_t              cdb_t_in,
    input  logic [N_WAY-1:0][4:0]      maptable_new_ar,
    input  logic [N_WAY-1:0][PR-1:0]   maptable_new_pr,
    input  logic [N_WAY-1:0][4:0]      reg1_ar,
    input  logic [N_WAY-1:0][4:0]      reg2_ar,
    output logic [N_WAY-1:0][PR-1:0]   reg1_tag,
    output logic [N_WAY-1:0][PR-1:0]   reg2_tag,
    output logic [N_WAY-1:0]           reg1_ready,
    output logic [N_WAY-1:0]           reg2_ready,
    output logic [N_WAY-1:0][PR-1:0]   Told_out
`ifdef MAP_TABLE_DISP_EN
    ,
    output logic [31:0][PR-1:0]        map_array_disp,
    output logic [31:0]                ready_array_disp
`endif
);

    logic [31:0][PR-1:0] map_q, map_d;
    logic [31:0]         rdy_q, rdy_d;
    logic [N_WAY-1:0]    told_rdy_unused;

    // Next table state: reset, then recovery, then CDB completions overridden by renames.
    always_comb begin
        map_d = map_q;
        rdy_d = rdy_q;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                map_d[i] = PR'(i);
                rdy_d[i] = 1'b1;
            end
        end else if (BPRecoverEN) begin
            map_d = archi_maptable;
            rdy_d = '1;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (cdb_hit(map_q[i], cdb_t_in)) begin
                    rdy_d[i] = 1'b1;
                end
            end
            // Oldest slot first so the youngest rename to a shared AR lands last.
            for (int s = N_WAY - 1; s >= 0; s--) begin
                if (maptable_new_ar[s] != 5'd0) begin
                    map_d[maptable_new_ar[s]] = maptable_new_pr[s];
                    rdy_d[maptable_new_ar[s]] = 1'b0;
                end
            end
        end
        map_d[0] = '0;
        rdy_d[0] = 1'b1;
    end

    // Table state register.
    always_ff @(posedge clock) begin
        map_q <= map_d;
        rdy_q <= rdy_d;
    end

    for (genvar k = 0; k < N_WAY; k++) begin : g_slot
        map_table_fwd #(.SLOT(k)) u_reg1 (
            .lookup_ar   (reg1_ar[k]),
            .entry_tag   (map_q[reg1_ar[k]]),
            .entry_ready (rdy_q[reg1_ar[k]]),
            .new_ar      (maptable_new_ar),
            .new_pr      (maptable_new_pr),
            .cdb_t_in    (cdb_t_in),
            .tag         (reg1_tag[k]),
            .ready       (reg1_ready[k])
        );
        map_table_fwd #(.SLOT(k)) u_reg2 (
            .lookup_ar   (reg2_ar[k]),
            .entry_tag   (map_q[reg2_ar[k]]),
            .entry_ready (rdy_q[reg2_ar[k]]),
            .new_ar      (maptable_new_ar),
            .new_pr      (maptable_new_pr),
            .cdb_t_in    (cdb_t_in),
            .tag         (reg2_tag[k]),
            .ready       (reg2_ready[k])
        );
        map_table_fwd #(.SLOT(k)) u_told (
            .lookup_ar   (maptable_new_ar[k]),
            .entry_tag   (map_q[maptable_new_ar[k]]),
            .entry_ready (rdy_q[maptable_new_ar[k]]),
            .new_ar      (maptable_new_ar),
            .new_pr      (maptable_new_pr),
            .cdb_t_in    (cdb_t_in),
            .tag         (Told_out[k]),
            .ready       (told_rdy_unused[k])
        );
    end

`ifdef MAP_TABLE_DISP_EN
    assign map_array_disp   = map_q;
    assign ready_array_disp = rdy_q;
`endif

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: identity reset, grouped renames with
// intra-group forwarding, CDB wakeup and bypass, rename-over-CDB priority,
// recovery and mid-operation reset. Display ports checked when
// MAP_TABLE_DISP_EN is defined.
module tb_map_table;
    import map_table_pkg::*;

    logic                      clock;
    logic                      reset;
    logic [31:0][PR-1:0]       archi_maptable;
    logic                      BPRecoverEN;
    cdb_t_packet_t             cdb_t_in;
    logic [N_WAY-1:0][4:0]     maptable_new_ar;
    logic [N_WAY-1:0][PR-1:0]  maptable_new_pr;
    logic [N_WAY-1:0][4:0]     reg1_ar;
    logic [N_WAY-1:0][4:0]     reg2_ar;
    logic [N_WAY-1:0][PR-1:0]  reg1_tag;
    logic [N_WAY-1:0][PR-1:0]  reg2_tag;
    logic [N_WAY-1:0]          reg1_ready;
    logic [N_WAY-1:0]          reg2_ready;
    logic [N_WAY-1:0][PR-1:0]  Told_out;
`ifdef MAP_TABLE_DISP_EN
    logic [31:0][PR-1:0]       map_array_disp;
    logic [31:0]               ready_array_disp;
`endif

    int n_cmp = 0;
    int n_err = 0;

    map_table dut (
        .clock           (clock),
        .reset           (reset),
        .archi_maptable  (archi_maptable),
        .BPRecoverEN     (BPRecoverEN),
        .cdb_t_in        (cdb_t_in),
        .maptable_new_ar (maptable_new_ar),
        .maptable_new_pr (maptable_new_pr),
        .reg1_ar         (reg1_ar),
        .reg2_ar         (reg2_ar),
        .reg1_tag        (reg1_tag),
        .reg2_tag        (reg2_tag),
        .reg1_ready      (reg1_ready),
        .reg2_ready      (reg2_ready),
        .Told_out        (Told_out)
`ifdef MAP_TABLE_DISP_EN
        ,
        .map_array_disp  (map_array_disp),
        .ready_array_disp(ready_array_disp)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        BPRecoverEN     = 1'b0;
        cdb_t_in        = '0;
        maptable_new_ar = '0;
        maptable_new_pr = '0;
    endtask

    // Look up one AR through reg1 of slot 2 (no older slots, so no forwarding).
    task automatic entry_is(input string tag, input logic [4:0] ar,
                            input logic [PR-1:0] exp_tag, input logic exp_rdy);
        reg1_ar[2] = ar;
        #1;
        check({tag, "_tag"}, 32'(reg1_tag[2]), 32'(exp_tag));
        check({tag, "_rdy"}, 32'(reg1_ready[2]), 32'(exp_rdy));
    endtask

    initial begin
        archi_maptable = '0;
        reg1_ar        = '0;
        reg2_ar        = '0;
        clear_ctl();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Identity map after reset.
        reg1_ar[2] = 5'd15;
        reg2_ar[0] = 5'd31;
        #1;
        check("rst_r1_tag", 32'(reg1_tag[2]), 32'd15);
        check("rst_r1_rdy", 32'(reg1_ready[2]), 32'd1);
        check("rst_r2_tag", 32'(reg2_tag[0]), 32'd31);
        check("rst_r2_rdy", 32'(reg2_ready[0]), 32'd1);
`ifdef MAP_TABLE_DISP_EN
        begin
            int bad = 0;
            for (int i = 0; i < 32; i++) if (map_array_disp[i] != PR'(i)) bad++;
            check("rst_disp_map_bad", 32'(bad), 32'd0);
            check("rst_disp_rdy", ready_array_disp, 32'hFFFF_FFFF);
        end
`endif

        // Group rename AR1->33 (slot2), AR2->34 (slot1), AR3->35 (slot0).
        maptable_new_ar = {5'd1, 5'd2, 5'd3};
        maptable_new_pr = {6'd33, 6'd34, 6'd35};
        reg1_ar = {5'd1, 5'd1, 5'd1};
        #1;
        check("ren_told2", 32'(Told_out[2]), 32'd1);
        check("ren_told1", 32'(Told_out[1]), 32'd2);
        check("ren_told0", 32'(Told_out[0]), 32'd3);
        check("ren_s2_tag", 32'(reg1_tag[2]), 32'd1);
        check("ren_s2_rdy", 32'(reg1_ready[2]), 32'd1);
        check("fwd_s0_tag", 32'(reg1_tag[0]), 32'd33);
        check("fwd_s0_rdy", 32'(reg1_ready[0]), 32'd0);
        check("fwd_s1_tag", 32'(reg1_tag[1]), 32'd33);
        step();
        clear_ctl();
        entry_is("e1", 5'd1, 6'd33, 1'b0);
        entry_is("e2", 5'd2, 6'd34, 1'b0);
        entry_is("e3", 5'd3, 6'd35, 1'b0);

        // CDB 33,34 with renames AR15->63, AR16->62, AR17->61.
        cdb_t_in.t0 = 6'd33;
        cdb_t_in.t1 = 6'd34;
        maptable_new_ar = {5'd15, 5'd16, 5'd17};
        maptable_new_pr = {6'd63, 6'd62, 6'd61};
        reg1_ar[2] = 5'd1;
        reg2_ar[2] = 5'd3;
        #1;
        check("byp_e1_tag", 32'(reg1_tag[2]), 32'd33);
        check("byp_e1_rdy", 32'(reg1_ready[2]), 32'd1);
        check("byp_e3_rdy", 32'(reg2_ready[2]), 32'd0);
        step();
        clear_ctl();
        entry_is("cdb_e1", 5'd1, 6'd33, 1'b1);
        entry_is("cdb_e2", 5'd2, 6'd34, 1'b1);
        entry_is("cdb_e3", 5'd3, 6'd35, 1'b0);
        entry_is("e15", 5'd15, 6'd63, 1'b0);
        entry_is("e16", 5'd16, 6'd62, 1'b0);
        entry_is("e17", 5'd17, 6'd61, 1'b0);

        // All slots rename AR11 -> 40/41/42, CDB 35.
        maptable_new_ar = {5'd11, 5'd11, 5'd11};
        maptable_new_pr = {6'd40, 6'd41, 6'd42};
        cdb_t_in.t0 = 6'd35;
        reg1_ar = {5'd3, 5'd0, 5'd11};
        #1;
        check("same_told2", 32'(Told_out[2]), 32'd11);
        check("same_told1", 32'(Told_out[1]), 32'd40);
        check("same_told0", 32'(Told_out[0]), 32'd41);
        check("byp_e3b_tag", 32'(reg1_tag[2]), 32'd35);
        check("byp_e3b_rdy", 32'(reg1_ready[2]), 32'd1);
        check("fwd_e11_tag", 32'(reg1_tag[0]), 32'd41);
        check("fwd_e11_rdy", 32'(reg1_ready[0]), 32'd0);
        check("ar0_tag", 32'(reg1_tag[1]), 32'd0);
        check("ar0_rdy", 32'(reg1_ready[1]), 32'd1);
        step();
        clear_ctl();
        entry_is("e11", 5'd11, 6'd42, 1'b0);
        entry_is("e3_woken", 5'd3, 6'd35, 1'b1);

        // Rename and CDB on the same entry: rename wins.
        cdb_t_in.t2 = 6'd42;
        maptable_new_ar[1] = 5'd11;
        maptable_new_pr[1] = 6'd43;
        step();
        clear_ctl();
        entry_is("ren_over_cdb", 5'd11, 6'd43, 1'b0);

        // Recovery to an all-zero committed map; rename/CDB that cycle ignored.
        BPRecoverEN = 1'b1;
        maptable_new_ar[0] = 5'd5;
        maptable_new_pr[0] = 6'd44;
        cdb_t_in.t0 = 6'd20;
        reg1_ar[2] = 5'd11;
        #1;
        check("rec_pre_tag", 32'(reg1_tag[2]), 32'd43);
        check("rec_pre_rdy", 32'(reg1_ready[2]), 32'd0);
        step();
        clear_ctl();
        entry_is("rec_e5", 5'd5, 6'd0, 1'b1);
        entry_is("rec_e11", 5'd11, 6'd0, 1'b1);
        entry_is("rec_e31", 5'd31, 6'd0, 1'b1);
`ifdef MAP_TABLE_DISP_EN
        check("rec_disp_map", 32'(map_array_disp != '0), 32'd0);
        check("rec_disp_rdy", ready_array_disp, 32'hFFFF_FFFF);
`endif

        // Mid-operation reset discards renames, including one presented with reset.
        maptable_new_ar[0] = 5'd7;
        maptable_new_pr[0] = 6'd45;
        step();
        clear_ctl();
        entry_is("pre_rst_e7", 5'd7, 6'd45, 1'b0);
        reset = 1'b1;
        maptable_new_ar[0] = 5'd8;
        maptable_new_pr[0] = 6'd46;
        step();
        reset = 1'b0;
        clear_ctl();
        entry_is("rst2_e7", 5'd7, 6'd7, 1'b1);
        entry_is("rst2_e8", 5'd8, 6'd8, 1'b1);
        entry_is("rst2_e5", 5'd5, 6'd5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
